exec_task_cmd_tx: RTL and testbench
===================================

EXEC_TASK_CMD_TX -- requirements
Module: exec_task_cmd_tx

Interface
REQ-001 SHALL have parameter MAX_ARGS, default 15, meaning the maximum number of task arguments buffered and sent (range 0..15, limited by the 4-bit arg index field).
REQ-002 SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports desc_valid in 1 / desc_ready out 1, the task descriptor handshake.
REQ-005 SHALL have desc_destid in 8, desc_compf in 8 and desc_num_args in 8, giving the destination accelerator, the compute flag and the argument count.
REQ-006 SHALL have desc_task_id in 64 and desc_parent_id in 64, giving the task and parent identifiers.
REQ-007 SHALL have arg_valid in 1, arg_ready out 1, arg_data in 64 and arg_flags in 8, the argument input stream carried in index order.
REQ-008 SHALL have out_tvalid out 1, out_tready in 1, out_tdata out 64, out_tlast out 1 and out_tdest out 8, the command stream to the accelerator.
REQ-009 SHALL have ack_valid in 1, ack_ready out 1, ack_code in 8 and ack_destid in 8, the accelerator acknowledge channel.
REQ-010 SHALL have done out 1, done_status out 2 and reject_count out 16, giving completion reporting and the count of rejects.

Function
REQ-011 SHALL implement an FSM with states IDLE, LOAD, HDR, TID, PID, ARGF, ARGV and WAIT_ACK.
REQ-012 IDLE: desc_ready=1; on desc_valid, the FSM SHALL latch all desc_* fields and go to LOAD if 0<N<=MAX_ARGS, to HDR if N=0, or to IDLE if N>MAX_ARGS, with done and done_status=2'b11 pulsed the next cycle and nothing sent.
REQ-013 LOAD: arg_ready=1; the FSM SHALL store one {flags,data} per arg handshake into an internal buffer at index 0..N-1 and go to HDR in the cycle after the Nth accept.
REQ-014 HDR word: [7:0]=0x01, [15:8]=N, [31:16]=0, [39:32]=compf, [47:40]=destid, [62:48]=0, [63]=1.
REQ-015 TID word = task_id and PID word = parent_id, sent in that order after HDR.
REQ-016 For each arg i=0..N-1, the block SHALL send an ARGF word with [7:0]=flags, [35:32]=i and all other bits 0, followed by an ARGV word equal to the arg data.
REQ-017 Each command SHALL be exactly 3+2N words; out_tlast SHALL be 1 only on the final word (PID when N=0).
REQ-018 out_tdest SHALL equal the latched destid for every word.
REQ-019 A word SHALL advance only on out_tvalid&&out_tready; out_tdata, out_tlast and out_tdest SHALL be held stable while out_tvalid&&!out_tready.
REQ-020 Words SHALL be sent back-to-back with no bubbles while out_tready=1, giving 1 word/cycle.
REQ-021 After the last word, the FSM SHALL enter WAIT_ACK with ack_ready=1, and ack_ready SHALL be 0 in every other state.
REQ-022 In WAIT_ACK, an ack with ack_destid!=latched destid SHALL be consumed and ignored.
REQ-023 On a matching ack with code 0x00 (reject), reject_count SHALL increment, saturating at 0xFFFF, and the FSM SHALL go to HDR and resend the identical command from the buffer without re-reading the arg stream.
REQ-024 On a matching ack with code 0x01 (OK), done SHALL pulse with done_status=2'b01 and the FSM SHALL go to IDLE.
REQ-025 On a matching ack with code 0x02 (final), done SHALL pulse with done_status=2'b10 and the FSM SHALL go to IDLE.
REQ-026 A matching ack with any other code SHALL be consumed and ignored, and the FSM SHALL remain in WAIT_ACK.
REQ-027 done SHALL be a 1-cycle pulse registered in the cycle after the ack handshake; desc_ready SHALL be 1 in that same cycle.
REQ-028 desc_valid outside IDLE SHALL have no effect (desc_ready=0); arg_valid outside LOAD SHALL have no effect (arg_ready=0).
REQ-029 Latency: the first out_tvalid SHALL occur one cycle after the last arg accept, or one cycle after the desc accept when N=0.

Reset
REQ-030 While rst=1, the state SHALL be IDLE and desc_ready, arg_ready, out_tvalid, out_tlast, ack_ready and done SHALL be 0.
REQ-031 While rst=1, out_tdata=0, out_tdest=0, done_status=0 and reject_count=0; desc_ready SHALL be 1 from the first clock edge after reset deasserts.
REQ-032 A rst assertion mid-command SHALL abort it immediately; no partial word SHALL remain valid and the buffer contents SHALL not matter.

Verification
REQ-033 N=2, destid=0x05, compf=0x01, task_id=0xA, parent_id=0xB, args {0x03,0x100},{0x01,0x200}, out_tready=1 -> 7 words: 0x8000_0501_0000_0201, 0xA, 0xB, 0x3, 0x100, 0x1_0000_0001, 0x200; tlast on word 7; ack 0x01 from 0x05 -> done with status 01.
REQ-034 N=0 -> words HDR(0x8000_....0001, N=0), TID, PID, with tlast on PID.
REQ-035 N=16 with MAX_ARGS=15 -> no output words; done with status 11 one cycle after the desc accept.
REQ-036 Ack 0x00 twice, then 0x02 -> the command is sent 3 times identically, reject_count=2 and done_status=10.
REQ-037 Randomised out_tready stalls -> the word sequence is unchanged and data is held during each stall; an ack from destid 0x06 while waiting on 0x05 is ignored.
REQ-038 rst asserted during ARGV -> all outputs are 0 at once; the next descriptor sent after reset is transmitted correctly.

Source files
------------

// File: rtl/exec_task_cmd_tx.sv
// exec_task_cmd_tx
// Accepts a task descriptor and its argument list, buffers the arguments,
// then streams a framed command (HDR, TID, PID, {ARGF, ARGV} x N) to an
// accelerator. It then waits for the accelerator acknowledge. A reject
// replays the identical command from the buffer. OK or final completes the task.
//
// Ports
//   clk, rst                       clock, async active-high reset
//   desc_valid/desc_ready          descriptor handshake
//   desc_destid/compf/num_args     destination, compute flag, argument count
//   desc_task_id/desc_parent_id    task and parent identifiers
//   arg_valid/arg_ready            argument stream handshake (index order)
//   arg_data/arg_flags             argument payload and flags
//   out_tvalid/tready/tdata/tlast/tdest   command stream
//   ack_valid/ack_ready/ack_code/ack_destid   acknowledge channel
//   done/done_status               completion pulse and status
//                                  (01 ok, 10 final, 11 too many args)
//   reject_count                   saturating count of rejects
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for a descriptor
// LOAD     | buffering arguments 0..N-1
// HDR      | sending header word
// TID      | sending task id word
// PID      | sending parent id word (last word when N=0)
// ARGF     | sending flags/index word for argument idx
// ARGV     | sending data word for argument idx
// WAIT_ACK | waiting for accelerator acknowledge

module exec_task_cmd_tx #(
    parameter int MAX_ARGS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [7:0]  desc_destid,
    input  logic [7:0]  desc_compf,
    input  logic [7:0]  desc_num_args,
    input  logic [63:0] desc_task_id,
    input  logic [63:0] desc_parent_id,
    input  logic        arg_valid,
    output logic        arg_ready,
    input  logic [63:0] arg_data,
    input  logic [7:0]  arg_flags,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic [63:0] out_tdata,
    output logic        out_tlast,
    output logic [7:0]  out_tdest,
    input  logic        ack_valid,
    output logic        ack_ready,
    input  logic [7:0]  ack_code,
    input  logic [7:0]  ack_destid,
    output logic        done,
    output logic [1:0]  done_status,
    output logic [15:0] reject_count
);

    typedef enum logic [2:0] {
        IDLE, LOAD, HDR, TID, PID, ARGF, ARGV, WAIT_ACK
    } state_t;

    // Keep at least one buffer entry so MAX_ARGS=0 still elaborates.
    localparam int         DEPTH = (MAX_ARGS < 1) ? 1 : MAX_ARGS;
    localparam logic [7:0] MAX_N = 8'(MAX_ARGS);

    state_t state, state_nxt;

    // Holds desc_ready low until the first clock after reset release.
    logic        out_of_reset;
    logic [7:0]  destid_q;
    logic [7:0]  compf_q;
    logic [7:0]  num_q;
    logic [63:0] task_q;
    logic [63:0] parent_q;
    logic [3:0]  idx;
    logic [7:0]  buf_flags [DEPTH];
    logic [63:0] buf_data  [DEPTH];

    logic [3:0]  last_idx;
    logic        done_set;
    logic [1:0]  done_code;
    logic        reject;

    // Only meaningful while 1 <= N <= 15, which is the only time it is used.
    assign last_idx  = num_q[3:0] - 4'd1;
    assign out_tdest = destid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        desc_ready = 1'b0;
        arg_ready  = 1'b0;
        out_tvalid = 1'b0;
        out_tdata  = 64'd0;
        out_tlast  = 1'b0;
        ack_ready  = 1'b0;
        done_set   = 1'b0;
        done_code  = 2'b00;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                desc_ready = out_of_reset;
                if (desc_valid && out_of_reset) begin
                    if (desc_num_args == 8'd0) begin
                        state_nxt = HDR;
                    end else if (desc_num_args > MAX_N) begin
                        state_nxt = IDLE;
                        done_set  = 1'b1;
                        done_code = 2'b11;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                arg_ready = 1'b1;
                if (arg_valid && idx == last_idx) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                out_tvalid = 1'b1;
                out_tdata  = {1'b1, 15'd0, destid_q, compf_q, 16'd0, num_q, 8'h01};
                if (out_tready) begin
                    state_nxt = TID;
                end
            end
            TID: begin
                out_tvalid = 1'b1;
                out_tdata  = task_q;
                if (out_tready) begin
                    state_nxt = PID;
                end
            end
            PID: begin
                out_tvalid = 1'b1;
                out_tdata  = parent_q;
                out_tlast  = (num_q == 8'd0);
                if (out_tready) begin
                    state_nxt = (num_q == 8'd0) ? WAIT_ACK : ARGF;
                end
            end
            ARGF: begin
                out_tvalid = 1'b1;
                out_tdata  = {28'd0, idx, 24'd0, buf_flags[idx]};
                if (out_tready) begin
                    state_nxt = ARGV;
                end
            end
            ARGV: begin
                out_tvalid = 1'b1;
                out_tdata  = buf_data[idx];
                out_tlast  = (idx == last_idx);
                if (out_tready) begin
                    state_nxt = (idx == last_idx) ? WAIT_ACK : ARGF;
                end
            end
            WAIT_ACK: begin
                ack_ready = 1'b1;
                // Acks for other destinations and unknown codes are consumed
                // without leaving this state.
                if (ack_valid && ack_destid == destid_q) begin
                    case (ack_code)
                        8'h00: begin
                            reject    = 1'b1;
                            state_nxt = HDR;
                        end
                        8'h01: begin
                            done_set  = 1'b1;
                            done_code = 2'b01;
                            state_nxt = IDLE;
                        end
                        8'h02: begin
                            done_set  = 1'b1;
                            done_code = 2'b10;
                            state_nxt = IDLE;
                        end
                        default: state_nxt = WAIT_ACK;
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_of_reset <= 1'b0;
            destid_q     <= 8'd0;
            compf_q      <= 8'd0;
            num_q        <= 8'd0;
            task_q       <= 64'd0;
            parent_q     <= 64'd0;
            idx          <= 4'd0;
            done         <= 1'b0;
            done_status  <= 2'b00;
            reject_count <= 16'd0;
        end else begin
            out_of_reset <= 1'b1;
            done         <= done_set;
            if (done_set) begin
                done_status <= done_code;
            end
            if (reject && reject_count != 16'hFFFF) begin
                reject_count <= reject_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (desc_valid && out_of_reset) begin
                        destid_q <= desc_destid;
                        compf_q  <= desc_compf;
                        num_q    <= desc_num_args;
                        task_q   <= desc_task_id;
                        parent_q <= desc_parent_id;
                        idx      <= 4'd0;
                    end
                end
                LOAD: begin
                    if (arg_valid) begin
                        idx <= idx + 4'd1;
                    end
                end
                PID: begin
                    if (out_tready) begin
                        idx <= 4'd0;
                    end
                end
                ARGV: begin
                    if (out_tready) begin
                        idx <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Argument buffer needs no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (state == LOAD && arg_valid) begin
            buf_flags[idx] <= arg_flags;
            buf_data[idx]  <= arg_data;
        end
    end

endmodule

// File: tb/tb_exec_task_cmd_tx.sv
module tb_exec_task_cmd_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        desc_valid;
    logic        desc_ready;
    logic [7:0]  desc_destid;
    logic [7:0]  desc_compf;
    logic [7:0]  desc_num_args;
    logic [63:0] desc_task_id;
    logic [63:0] desc_parent_id;
    logic        arg_valid;
    logic        arg_ready;
    logic [63:0] arg_data;
    logic [7:0]  arg_flags;
    logic        out_tvalid;
    logic        out_tready;
    logic [63:0] out_tdata;
    logic        out_tlast;
    logic [7:0]  out_tdest;
    logic        ack_valid;
    logic        ack_ready;
    logic [7:0]  ack_code;
    logic [7:0]  ack_destid;
    logic        done;
    logic [1:0]  done_status;
    logic [15:0] reject_count;

    exec_task_cmd_tx #(.MAX_ARGS(15)) dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_destid(desc_destid), .desc_compf(desc_compf),
        .desc_num_args(desc_num_args), .desc_task_id(desc_task_id),
        .desc_parent_id(desc_parent_id),
        .arg_valid(arg_valid), .arg_ready(arg_ready),
        .arg_data(arg_data), .arg_flags(arg_flags),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tdest(out_tdest),
        .ack_valid(ack_valid), .ack_ready(ack_ready),
        .ack_code(ack_code), .ack_destid(ack_destid),
        .done(done), .done_status(done_status), .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // word = {tlast, tdest, tdata}
    logic [72:0] got_q[$];
    logic [72:0] exp_q[$];
    logic [7:0]  a_flags [16];
    logic [63:0] a_data  [16];

    int          stall_viol = 0;
    int          stall_seen = 0;
    logic        prev_stall = 1'b0;
    logic [72:0] prev_word  = '0;
    bit          rand_ready = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!out_tvalid || {out_tlast, out_tdest, out_tdata} !== prev_word))
                stall_viol++;
            if (out_tvalid && out_tready)
                got_q.push_back({out_tlast, out_tdest, out_tdata});
            prev_stall = out_tvalid && !out_tready;
            if (prev_stall) stall_seen++;
            prev_word = {out_tlast, out_tdest, out_tdata};
        end
    end

    initial begin
        out_tready = 1'b1;
        forever begin
            @(negedge clk);
            out_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference command image built from the bench's own argument tables.
    task automatic add_cmd(input logic [7:0] dest, input logic [7:0] compf, input logic [7:0] n,
                           input logic [63:0] tid, input logic [63:0] pid);
        exp_q.push_back({1'b0, dest, {1'b1, 15'd0, dest, compf, 16'd0, n, 8'h01}});
        exp_q.push_back({1'b0, dest, tid});
        exp_q.push_back({(n == 8'd0), dest, pid});
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({1'b0, dest, {28'd0, 4'(i), 24'd0, a_flags[i]}});
            exp_q.push_back({(i == int'(n) - 1), dest, a_data[i]});
        end
    endtask

    task automatic send_desc(input logic [7:0] dest, input logic [7:0] compf, input logic [7:0] n,
                             input logic [63:0] tid, input logic [63:0] pid, output bit ok);
        int cnt = 0;
        ok = 1'b1;
        desc_valid = 1'b1; desc_destid = dest; desc_compf = compf;
        desc_num_args = n; desc_task_id = tid; desc_parent_id = pid;
        @(posedge clk);
        while (!desc_ready) begin
            cnt++;
            if (cnt > 200) begin ok = 1'b0; break; end
            @(posedge clk);
        end
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    task automatic send_args(input logic [7:0] n, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            int cnt = 0;
            arg_valid = 1'b1; arg_flags = a_flags[i]; arg_data = a_data[i];
            @(posedge clk);
            while (!arg_ready) begin
                cnt++;
                if (cnt > 200) begin ok = 1'b0; break; end
                @(posedge clk);
            end
            @(negedge clk);
            arg_valid = 1'b0;
        end
    endtask

    task automatic send_ack(input logic [7:0] code, input logic [7:0] dest, output bit ok,
                            output logic d, output logic [1:0] st, output logic dr, output logic ar);
        int cnt = 0;
        ok = 1'b1;
        ack_valid = 1'b1; ack_code = code; ack_destid = dest;
        @(posedge clk);
        while (!ack_ready) begin
            cnt++;
            if (cnt > 300) begin ok = 1'b0; break; end
            @(posedge clk);
        end
        @(negedge clk);
        ack_valid = 1'b0;
        d = done; st = done_status; dr = desc_ready; ar = ack_ready;
    endtask

    task automatic wait_words(input int n, output bit ok);
        int cnt = 0;
        ok = 1'b1;
        while (got_q.size() < n) begin
            cnt++;
            if (cnt > 400) begin ok = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        desc_valid = 0; desc_destid = 0; desc_compf = 0; desc_num_args = 0;
        desc_task_id = 0; desc_parent_id = 0;
        arg_valid = 0; arg_data = 0; arg_flags = 0;
        ack_valid = 0; ack_code = 0; ack_destid = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({desc_ready, arg_ready, out_tvalid, out_tlast, ack_ready, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {desc_ready, arg_ready, out_tvalid, out_tlast, ack_ready, done});
        end
        checks++;
        if (out_tdata !== 64'd0 || out_tdest !== 8'd0 || done_status !== 2'd0 || reject_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: tdata=%h tdest=%h status=%b rej=%0d expected all zero",
                     out_tdata, out_tdest, done_status, reject_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (desc_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 0 before first edge", desc_ready);
        end
        @(negedge clk);
        checks++;
        if (desc_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after_edge: got %b expected 1", desc_ready);
        end
    endtask

    task automatic test_basic();
        bit ok; logic d, dr, ar; logic [1:0] st;
        got_q.delete(); exp_q.delete();
        a_flags[0] = 8'h03; a_data[0] = 64'h100;
        a_flags[1] = 8'h01; a_data[1] = 64'h200;
        add_cmd(8'h05, 8'h01, 8'd2, 64'hA, 64'hB);
        send_desc(8'h05, 8'h01, 8'd2, 64'hA, 64'hB, ok);
        send_args(8'd2, ok);
        checks++;
        if (!ok || out_tvalid !== 1'b1 || desc_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: ok=%0d tvalid=%b desc_ready=%b expected 1,1,0", ok, out_tvalid, desc_ready);
        end
        wait_words(7, ok);
        checks++;
        if (!ok || got_q.size() != 7 || ack_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_count: words=%0d ack_ready=%b expected 7,1", got_q.size(), ack_ready);
        end
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q.size() == 7 && (got_q[0][63:0] !== 64'h8000_0501_0000_0201 ||
                                  got_q[5][63:0] !== 64'h1_0000_0001 || got_q[6][72] !== 1'b1)) begin
            errors++;
            $display("FAIL basic_literal: hdr=%h argf1=%h last=%b expected 8000050100000201,100000001,1",
                     got_q[0][63:0], got_q[5][63:0], got_q[6][72]);
        end
        send_ack(8'h01, 8'h05, ok, d, st, dr, ar);
        checks++;
        if (!ok || d !== 1'b1 || st !== 2'b01 || dr !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: done=%b status=%b desc_ready=%b expected 1,01,1", d, st, dr);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b expected 0", done);
        end
    endtask

    task automatic test_zero_args();
        bit ok; logic d, dr, ar; logic [1:0] st;
        got_q.delete(); exp_q.delete();
        add_cmd(8'h22, 8'h00, 8'd0, 64'h1122_3344_5566_7788, 64'hCAFE_F00D_0000_0001);
        arg_valid = 1'b1; arg_data = 64'hBAD; arg_flags = 8'hEE;
        send_desc(8'h22, 8'h00, 8'd0, 64'h1122_3344_5566_7788, 64'hCAFE_F00D_0000_0001, ok);
        checks++;
        if (!ok || out_tvalid !== 1'b1 || arg_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_latency: tvalid=%b arg_ready=%b expected 1,0", out_tvalid, arg_ready);
        end
        wait_words(3, ok);
        arg_valid = 1'b0;
        checks++;
        if (!ok || got_q.size() != 3) begin
            errors++;
            $display("FAIL zero_count: words=%0d expected 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL zero_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q.size() == 3 && got_q[0][63:0] !== 64'h8000_2200_0000_0001) begin
            errors++;
            $display("FAIL zero_hdr: got %h expected 8000220000000001", got_q[0][63:0]);
        end
        send_ack(8'h02, 8'h22, ok, d, st, dr, ar);
        checks++;
        if (!ok || d !== 1'b1 || st !== 2'b10) begin
            errors++;
            $display("FAIL zero_done: done=%b status=%b expected 1,10", d, st);
        end
    endtask

    task automatic test_too_many();
        bit ok;
        got_q.delete();
        send_desc(8'h05, 8'h01, 8'd16, 64'h1, 64'h2, ok);
        checks++;
        if (!ok || done !== 1'b1 || done_status !== 2'b11 || out_tvalid !== 1'b0 || desc_ready !== 1'b1) begin
            errors++;
            $display("FAIL too_many_done: done=%b status=%b tvalid=%b desc_ready=%b expected 1,11,0,1",
                     done, done_status, out_tvalid, desc_ready);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || arg_ready !== 1'b0) begin
            errors++;
            $display("FAIL too_many_nothing_sent: words=%0d arg_ready=%b expected 0,0", got_q.size(), arg_ready);
        end
    endtask

    task automatic test_reject_retry();
        bit ok; logic d, dr, ar; logic [1:0] st;
        got_q.delete(); exp_q.delete();
        a_flags[0] = 8'h80; a_data[0] = 64'hDEAD_BEEF_0123_4567;
        for (int k = 0; k < 3; k++) add_cmd(8'h07, 8'h02, 8'd1, 64'h77, 64'h88);
        send_desc(8'h07, 8'h02, 8'd1, 64'h77, 64'h88, ok);
        send_args(8'd1, ok);
        wait_words(5, ok);
        send_ack(8'h00, 8'h07, ok, d, st, dr, ar);
        checks++;
        if (!ok || d !== 1'b0 || reject_count !== 16'd1) begin
            errors++;
            $display("FAIL reject_first: done=%b rej=%0d expected 0,1", d, reject_count);
        end
        wait_words(10, ok);
        send_ack(8'h00, 8'h07, ok, d, st, dr, ar);
        wait_words(15, ok);
        send_ack(8'h02, 8'h07, ok, d, st, dr, ar);
        checks++;
        if (!ok || d !== 1'b1 || st !== 2'b10 || reject_count !== 16'd2) begin
            errors++;
            $display("FAIL reject_final: done=%b status=%b rej=%0d expected 1,10,2", d, st, reject_count);
        end
        checks++;
        if (got_q.size() != 15) begin
            errors++;
            $display("FAIL reject_count_words: got %0d expected 15", got_q.size());
        end
        for (int i = 0; i < 15 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reject_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        bit ok; logic d, dr, ar; logic [1:0] st;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 15; i++) begin
            a_flags[i] = 8'(i * 3 + 1);
            a_data[i]  = 64'h1000 + 64'(i) * 64'h11111;
        end
        add_cmd(8'h05, 8'h33, 8'd15, 64'h5555, 64'h6666);
        stall_viol = 0; stall_seen = 0;
        rand_ready = 1'b1;
        send_desc(8'h05, 8'h33, 8'd15, 64'h5555, 64'h6666, ok);
        send_args(8'd15, ok);
        wait_words(33, ok);
        rand_ready = 1'b0;
        checks++;
        if (!ok || got_q.size() != 33) begin
            errors++;
            $display("FAIL stall_count: words=%0d expected 33", got_q.size());
        end
        for (int i = 0; i < 33 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stall_viol != 0 || stall_seen == 0) begin
            errors++;
            $display("FAIL stall_hold: violations=%0d stalls=%0d expected 0,>0", stall_viol, stall_seen);
        end
        send_ack(8'h01, 8'h06, ok, d, st, dr, ar);
        checks++;
        if (!ok || d !== 1'b0 || ar !== 1'b1) begin
            errors++;
            $display("FAIL stall_wrong_dest: done=%b ack_ready=%b expected 0,1", d, ar);
        end
        send_ack(8'h09, 8'h05, ok, d, st, dr, ar);
        checks++;
        if (!ok || d !== 1'b0 || ar !== 1'b1) begin
            errors++;
            $display("FAIL stall_unknown_code: done=%b ack_ready=%b expected 0,1", d, ar);
        end
        send_ack(8'h01, 8'h05, ok, d, st, dr, ar);
        checks++;
        if (!ok || d !== 1'b1 || st !== 2'b01) begin
            errors++;
            $display("FAIL stall_done: done=%b status=%b expected 1,01", d, st);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; logic d, dr, ar; logic [1:0] st;
        got_q.delete(); exp_q.delete();
        a_flags[0] = 8'h03; a_data[0] = 64'h100;
        a_flags[1] = 8'h01; a_data[1] = 64'h200;
        send_desc(8'h05, 8'h01, 8'd2, 64'hA, 64'hB, ok);
        send_args(8'd2, ok);
        wait_words(4, ok);
        checks++;
        if (!ok || out_tvalid !== 1'b1 || out_tdata !== 64'h100) begin
            errors++;
            $display("FAIL mid_in_argv: tvalid=%b tdata=%h expected 1,100", out_tvalid, out_tdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_tvalid, out_tlast, desc_ready, arg_ready, ack_ready, done} !== 6'b0 ||
            out_tdata !== 64'd0 || out_tdest !== 8'd0 || reject_count !== 16'd0 || done_status !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ctrl=%b tdata=%h tdest=%h rej=%0d status=%b expected all zero",
                     {out_tvalid, out_tlast, desc_ready, arg_ready, ack_ready, done},
                     out_tdata, out_tdest, reject_count, done_status);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        got_q.delete();
        a_flags[0] = 8'h5A; a_data[0] = 64'hFEED_0000_0000_0009;
        add_cmd(8'h09, 8'h04, 8'd1, 64'h99, 64'hAA);
        send_desc(8'h09, 8'h04, 8'd1, 64'h99, 64'hAA, ok);
        send_args(8'd1, ok);
        wait_words(5, ok);
        checks++;
        if (!ok || got_q.size() != 5) begin
            errors++;
            $display("FAIL mid_after_count: words=%0d expected 5", got_q.size());
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_after_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        send_ack(8'h01, 8'h09, ok, d, st, dr, ar);
        checks++;
        if (!ok || d !== 1'b1 || st !== 2'b01) begin
            errors++;
            $display("FAIL mid_after_done: done=%b status=%b expected 1,01", d, st);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_args();
        test_too_many();
        test_reject_retry();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
